// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream interface.
// The operands are split into STAGES chunks of W bits; chunk k is added in stage k
// using the carry registered by stage k-1. Each stage register carries the full
// operand and partial-sum vectors, so the still-unused upper operand chunks ride
// along (skew) and the finished lower sum chunks stay aligned (deskew) until the
// last stage presents the complete result.
module pipelined_rca #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         Sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int unsigned W = N / STAGES;
    localparam int unsigned L = STAGES - 1;

    // Per-stage pipeline registers
    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] a_d [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] b_d [STAGES];
    logic [N-1:0] s_q [STAGES];
    logic [N-1:0] s_d [STAGES];
    logic         c_q [STAGES];
    logic         c_d [STAGES];
    logic         v_q [STAGES];
    logic         v_d [STAGES];
    logic         ovf_q;
    logic         ovf_d;

    // Stage inputs and per-stage chunk results
    logic [N-1:0] a_src [STAGES];
    logic [N-1:0] b_src [STAGES];
    logic [N-1:0] s_src [STAGES];
    logic         c_src [STAGES];
    logic         v_src [STAGES];
    logic [W:0]   chunk [STAGES];
    logic         advance;

    // Stage 0 sees the conditioned operands; stage k sees register k-1.
    // Subtraction is A + ~B + ~Cin, so Cout=1 means "no borrow".
    always_comb begin
        a_src[0] = A;
        b_src[0] = Sub ? ~B : B;
        c_src[0] = Sub ? ~Cin : Cin;
        s_src[0] = '0;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    // Each stage ripples its own W-bit chunk, producing W sum bits plus carry-out
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, a_src[k][k*W +: W]} + {1'b0, b_src[k][k*W +: W]}
                     + {{W{1'b0}}, c_src[k]};
        end
    end

    // Global stall: the whole pipe, bubbles included, moves only when the output
    // slot is empty or being drained this cycle.
    always_comb begin
        advance = ~v_q[L] | out_ready;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            c_d[k] = c_q[k];
            v_d[k] = v_q[k];
            if (advance) begin
                a_d[k]             = a_src[k];
                b_d[k]             = b_src[k];
                s_d[k]             = s_src[k];
                s_d[k][k*W +: W]   = chunk[k][W-1:0];
                c_d[k]             = chunk[k][W];
                v_d[k]             = v_src[k];
            end
        end
        // Carry into the MSB is recovered as a ^ b ^ sum at bit N-1
        ovf_d = ovf_q;
        if (advance) begin
            ovf_d = (a_src[L][N-1] ^ b_src[L][N-1] ^ chunk[L][W-1]) ^ chunk[L][W];
        end
    end

    // Pipeline state; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = advance;
    assign Sum       = s_q[L];
    assign Cout      = c_q[L];
    assign Ovf       = ovf_q;
    assign out_valid = v_q[L];

endmodule
